// File: rtl/kamus_pkg.sv
// Shared constants and types for the kamus L1D responder: MMIO word offsets,
// address-region decode type and the timer compare reset value.
package kamus_pkg;

   localparam logic [15:0] MMIO_MTIME_LO    = 16'h0000;
   localparam logic [15:0] MMIO_MTIME_HI    = 16'h0004;
   localparam logic [15:0] MMIO_MTIMECMP_LO = 16'h0008;
   localparam logic [15:0] MMIO_MTIMECMP_HI = 16'h000C;
   localparam logic [15:0] MMIO_TOHOST      = 16'h0010;

   localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

   typedef enum logic {
      REG_RAM  = 1'b0,
      REG_MMIO = 1'b1
   } l1d_region_e;

endpackage

// File: rtl/kamus_mtimer.sv
// 64-bit machine timer with compare register and registered interrupt.
// Software writes to either counter half take priority over that cycle's increment.
module kamus_mtimer
   import kamus_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_we_mtime_lo,
   input  logic        i_we_mtime_hi,
   input  logic        i_we_cmp_lo,
   input  logic        i_we_cmp_hi,
   input  logic [31:0] i_wr_data,
   output logic [63:0] o_mtime,
   output logic [63:0] o_mtimecmp,
   output logic        o_irq
);

   logic [63:0] r_mtime;
   logic [63:0] r_mtimecmp;
   logic        r_irq;
   logic [63:0] w_mtime_next;
   logic [63:0] w_mtimecmp_next;

   always_comb begin
      w_mtime_next = r_mtime + 64'd1;
      if (i_we_mtime_lo) begin
         w_mtime_next = {r_mtime[63:32], i_wr_data};
      end else if (i_we_mtime_hi) begin
         w_mtime_next = {i_wr_data, r_mtime[31:0]};
      end
   end

   always_comb begin
      w_mtimecmp_next = r_mtimecmp;
      if (i_we_cmp_lo) begin
         w_mtimecmp_next = {r_mtimecmp[63:32], i_wr_data};
      end else if (i_we_cmp_hi) begin
         w_mtimecmp_next = {i_wr_data, r_mtimecmp[31:0]};
      end
   end

   // irq is computed from next-state values so it lines up with the counter it describes
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_mtime    <= 64'd0;
         r_mtimecmp <= MTIMECMP_RST;
         r_irq      <= 1'b0;
      end else begin
         r_mtime    <= w_mtime_next;
         r_mtimecmp <= w_mtimecmp_next;
         r_irq      <= (w_mtime_next >= w_mtimecmp_next);
      end
   end

   assign o_mtime    = r_mtime;
   assign o_mtimecmp = r_mtimecmp;
   assign o_irq      = r_irq;

endmodule

// File: rtl/kamus_l1d_responder.sv
// L1D slave: word RAM with zero-latency reads plus an MMIO window holding the
// machine timer (present only with KAMUS_L1D_TIMER_EN defined) and TOHOST.
module kamus_l1d_responder
   import kamus_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        l1d_wr_en_i,
   input  logic [31:0] l1d_addr_i,
   input  logic [31:0] l1d_wr_data_i,
   output logic [31:0] l1d_rd_data_o,
   output logic        timer_irq_o,
   output logic        test_done_o,
   output logic        test_pass_o,
   output logic [30:0] test_code_o
);

   localparam int AW = $clog2(DEPTH_WORDS);

   logic [31:0]  r_ram [DEPTH_WORDS];
   logic         r_done;
   logic         r_pass;
   logic [30:0]  r_code;

   l1d_region_e  w_region;
   logic [15:0]  w_off;
   logic [AW-1:0] w_ram_idx;
   logic         w_ram_we;
   logic         w_mmio_we;
   logic [31:0]  w_mmio_rd;
   logic         w_unused;

   assign w_region  = (l1d_addr_i[31:16] == MMIO_BASE[31:16]) ? REG_MMIO : REG_RAM;
   assign w_off     = {l1d_addr_i[15:2], 2'b00};
   assign w_ram_idx = l1d_addr_i[AW+1:2];
   assign w_ram_we  = l1d_wr_en_i && (w_region == REG_RAM) && !rst_i;
   assign w_mmio_we = l1d_wr_en_i && (w_region == REG_MMIO);
   assign w_unused  = ^{l1d_addr_i[1:0], MMIO_BASE[15:0]};

   always_ff @(posedge clk_i) begin
      if (w_ram_we) begin
         r_ram[w_ram_idx] <= l1d_wr_data_i;
      end
   end

   // only the first write with bit 0 set is captured; later ones are ignored
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_done <= 1'b0;
         r_pass <= 1'b0;
         r_code <= '0;
      end else if (w_mmio_we && (w_off == MMIO_TOHOST) && l1d_wr_data_i[0] && !r_done) begin
         r_done <= 1'b1;
         r_pass <= (l1d_wr_data_i[31:1] == 31'd0);
         r_code <= l1d_wr_data_i[31:1];
      end
   end

`ifdef KAMUS_L1D_TIMER_EN
   logic [63:0] w_mtime;
   logic [63:0] w_mtimecmp;
   logic        w_irq;

   kamus_mtimer u_mtimer (
      .i_clk         (clk_i),
      .i_rst         (rst_i),
      .i_we_mtime_lo (w_mmio_we && (w_off == MMIO_MTIME_LO)),
      .i_we_mtime_hi (w_mmio_we && (w_off == MMIO_MTIME_HI)),
      .i_we_cmp_lo   (w_mmio_we && (w_off == MMIO_MTIMECMP_LO)),
      .i_we_cmp_hi   (w_mmio_we && (w_off == MMIO_MTIMECMP_HI)),
      .i_wr_data     (l1d_wr_data_i),
      .o_mtime       (w_mtime),
      .o_mtimecmp    (w_mtimecmp),
      .o_irq         (w_irq)
   );

   assign timer_irq_o = w_irq;
`else
   assign timer_irq_o = 1'b0;
`endif

   always_comb begin
      w_mmio_rd = 32'd0;
      case (w_off)
`ifdef KAMUS_L1D_TIMER_EN
         MMIO_MTIME_LO:    w_mmio_rd = w_mtime[31:0];
         MMIO_MTIME_HI:    w_mmio_rd = w_mtime[63:32];
         MMIO_MTIMECMP_LO: w_mmio_rd = w_mtimecmp[31:0];
         MMIO_MTIMECMP_HI: w_mmio_rd = w_mtimecmp[63:32];
`endif
         MMIO_TOHOST:      w_mmio_rd = {r_code, r_done};
         default:          w_mmio_rd = 32'd0;
      endcase
   end

   assign l1d_rd_data_o = (w_region == REG_MMIO) ? w_mmio_rd : r_ram[w_ram_idx];

   assign test_done_o = r_done;
   assign test_pass_o = r_pass;
   assign test_code_o = r_code;

endmodule
